granule_reorder: RTL
====================

// Module: granule_reorder
// PURPOSE
// - Stage directly downstream of the requantizer.
// - Collects one granule (576 samples) of requantized values, each tagged with its frequency-line index.
// - Emits all 576 lines in output order. Long blocks pass through in index order.
// - Short blocks are re-interleaved from window-major to frequency-major order within each short scalefactor band (sfb).
// - Lines never written in a granule read back as 0. This covers the rzero region the requantizer never emits.
// PARAMETERS
// - DATA_W       16   sample width (two's complement)
// - IDX_W        10   frequency-line index width
// - GRANULE_LEN  576  lines per granule
// - Short-sfb widths are fixed at the 44.1 kHz table: 4,4,4,4,6,8,10,12,14,18,22,30,56.
// PORTS
// - clk        in   1       clock
// - rst        in   1       asynchronous, active-low reset (asserted at 0)
// - si_valid   in   1       1-cycle pulse; side info below is valid
// - window_switching_flag  in  1  side info
// - block_type in   2       side info
// - mixed_block_flag       in  1  side info
// - din_valid  in   1       requantized sample valid
// - din_ready  out  1       block accepts a sample this cycle
// - x_in       in   DATA_W  requantized sample
// - x_base_in  in   IDX_W   line index of x_in
// - din_last   in   1       qualifies the final sample of the granule
// - dout_valid out  1       output sample valid
// - dout_ready in   1       consumer accepts the output
// - x_out      out  DATA_W  reordered sample
// - x_idx_out  out  IDX_W   output line index, 0..575
// - busy       out  1       not in IDLE
// BEHAVIOUR
// - Reset: state IDLE; dout_valid, x_out, x_idx_out, din_ready, busy all 0; written-bitmap cleared.
// - IDLE -> FILL on si_valid.
//   - Latch short = window_switching_flag && block_type==2, and mixed = short && mixed_block_flag.
//   - Clear the 576-bit written bitmap.
// - FILL: din_ready=1. A sample is accepted when din_valid && din_ready.
//   - Store x_in at x_base_in and set its bitmap bit.
//   - x_base_in >= 576 is dropped but still counts for din_last.
//   - Duplicate index: last write wins.
//   - Accepted din_last -> DRAIN on the next cycle.
//   - si_valid during FILL or DRAIN is ignored.
// - DRAIN: din_ready=0.
//   - Output counter o runs 0..575; x_idx_out=o.
//   - Read address a(o) is held in registered counters (sfb, j, w, base). No multiplier.
//   - Long block: a=o.
//   - Short block, per sfb with start s and width n: a = 3*s + w*n + j. w is the inner loop (0..2), then j (0..n-1).
//   - Mixed block: o<36 -> a=o; short mapping starts at sfb 3 (3*s=36).
//   - x_out = bitmap[a] ? mem[a] : 0.
// - Latency and handshake:
//   - Synchronous RAM read; first dout_valid 1 cycle after entering DRAIN.
//   - While dout_valid && !dout_ready, x_out and x_idx_out hold stable and the counters stall.
//   - After the o=575 transfer: dout_valid=0 next cycle, then IDLE.
// - Reset mid-operation aborts immediately. No partial output resumes; the next granule starts with a cleared bitmap.
// - din_valid outside FILL is not accepted (din_ready=0). Source must hold it.
// CONFIGURATION
// - GRANULE_REORDER_PINGPONG_EN defined:
//   - Two 576-entry banks with per-bank bitmaps.
//   - FILL of granule N+1 overlaps DRAIN of granule N.
//   - si_valid is accepted while draining if the other bank is free.
//   - din_ready=1 whenever a fill bank is open.
//   - Drain order across granules is strictly FIFO.
// - Undefined: single bank; FILL and DRAIN are mutually exclusive as above.
// TESTING
// - Long: si(wsf=0); write idx0..3 = 7,4,-4,32, last@3 -> out idx0..3 = 7,4,-4,32; idx4..575 = 0; 576 beats, in order.
// - Short (wsf=1, bt=2): x[k]=k for all k, last@575.
//   - Out idx0..11 = 0,4,8,1,5,9,2,6,10,3,7,11.
//   - Out idx408..410 = 408,464,520.
// - Mixed: x[k]=k -> idx0..35 = 0..35; idx36..38 = 36,40,44.
// - Backpressure: dout_ready=0 for 5 cycles at o=100 -> x_out/x_idx_out stable; resumes at 100, no skip or duplicate.
// - Edge writes: idx600 dropped; idx5 written 3 then 9 -> out5=9.
//   - rst=0 mid-DRAIN -> all outputs 0 and IDLE.
//   - Next granule writes idx0 only -> idx1..575 = 0.
// - PINGPONG_EN: second granule filled during first drain -> drains back-to-back with no gap beyond 1 cycle, order preserved.

Source files
------------

// File: rtl/granule_reorder.sv
// Granule reorder buffer: collects 576 indexed requantized lines and drains them in output order.
// Optional macro GRANULE_REORDER_PINGPONG_EN enables a second bank so filling overlaps draining.
module granule_reorder #(
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 10,
  parameter int GRANULE_LEN = 576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     si_valid,
  input  logic                     window_switching_flag,
  input  logic [1:0]               block_type,
  input  logic                     mixed_block_flag,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic [IDX_W-1:0]         x_base_in,
  input  logic                     din_last,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic [IDX_W-1:0]         x_idx_out,
  output logic                     busy
);

`ifdef GRANULE_REORDER_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(GRANULE_LEN - 1);
  localparam logic [IDX_W-1:0] MIXED_END = IDX_W'(36);

  typedef enum logic {ST_IDLE, ST_FILL} fstate_t;

  // Short-block sfb widths at 44.1 kHz; index 13 only appears after the last line.
  function automatic logic [5:0] sfb_width(input logic [3:0] sfb);
    case (sfb)
      4'd0, 4'd1, 4'd2, 4'd3: sfb_width = 6'd4;
      4'd4:                   sfb_width = 6'd6;
      4'd5:                   sfb_width = 6'd8;
      4'd6:                   sfb_width = 6'd10;
      4'd7:                   sfb_width = 6'd12;
      4'd8:                   sfb_width = 6'd14;
      4'd9:                   sfb_width = 6'd18;
      4'd10:                  sfb_width = 6'd22;
      4'd11:                  sfb_width = 6'd30;
      4'd12:                  sfb_width = 6'd56;
      default:                sfb_width = 6'd0;
    endcase
  endfunction

  fstate_t f_state_q, f_state_d;
  logic    fb_q, db_q;
  logic [1:0] full_q, short_q, mixed_q;
  logic [GRANULE_LEN-1:0] bm_q [2];
  logic signed [DATA_W-1:0] mem_q [2][GRANULE_LEN];

  logic                     vld_q, iss_done_q;
  logic signed [DATA_W-1:0] x_out_q;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         o_q, o_d, base_q, base_d, wn_q, wn_d;
  logic [3:0]               sfb_q, sfb_d;
  logic [5:0]               j_q, j_d;
  logic [1:0]               w_q, w_d;

  logic si_acc, din_acc, in_range, si_short;
  logic drain_act, adv, short_b, mixed_b, long_rgn;
  logic [5:0]       wid;
  logic [IDX_W-1:0] rd_addr;

  assign si_short = window_switching_flag && (block_type == 2'd2);
  assign in_range = x_base_in < IDX_W'(GRANULE_LEN);

  // Fill-side FSM: a new granule opens only when its target bank is free.
  always_comb begin
    f_state_d = f_state_q;
    si_acc    = 1'b0;
    din_acc   = 1'b0;
    din_ready = 1'b0;
    case (f_state_q)
      ST_IDLE: begin
        if (si_valid && !full_q[fb_q]) begin
          si_acc    = 1'b1;
          f_state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        din_ready = 1'b1;
        if (din_valid) begin
          din_acc = 1'b1;
          if (din_last) f_state_d = ST_IDLE;
        end
      end
      default: f_state_d = ST_IDLE;
    endcase
  end

  assign drain_act = full_q[db_q];
  assign adv       = drain_act && (!vld_q || dout_ready);
  assign short_b   = short_q[db_q];
  assign mixed_b   = mixed_q[db_q];
  assign long_rgn  = !short_b || (mixed_b && (o_q < MIXED_END));
  assign wid       = sfb_width(sfb_q);
  assign rd_addr   = long_rgn ? o_q : (base_q + wn_q + IDX_W'(j_q));

  // Read-address walk: window is the inner loop, line-in-window the outer, all additive.
  always_comb begin
    o_d    = o_q + 1'b1;
    sfb_d  = sfb_q;
    j_d    = j_q;
    w_d    = w_q;
    base_d = base_q;
    wn_d   = wn_q;
    if (long_rgn) begin
      if (mixed_b && (o_q == MIXED_END - 1'b1)) begin
        sfb_d  = 4'd3;
        base_d = MIXED_END;
      end
    end else if (w_q == 2'd2) begin
      w_d  = 2'd0;
      wn_d = '0;
      if (j_q == wid - 6'd1) begin
        j_d    = 6'd0;
        sfb_d  = sfb_q + 4'd1;
        base_d = base_q + IDX_W'({wid, 1'b0}) + IDX_W'(wid);
      end else begin
        j_d = j_q + 6'd1;
      end
    end else begin
      w_d  = w_q + 2'd1;
      wn_d = wn_q + IDX_W'(wid);
    end
  end

  always_ff @(posedge clk) begin
    if (din_acc && in_range) mem_q[fb_q][x_base_in] <= x_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_state_q  <= ST_IDLE;
      fb_q       <= 1'b0;
      db_q       <= 1'b0;
      full_q     <= '0;
      short_q    <= '0;
      mixed_q    <= '0;
      bm_q[0]    <= '0;
      bm_q[1]    <= '0;
      vld_q      <= 1'b0;
      iss_done_q <= 1'b0;
      x_out_q    <= '0;
      idx_q      <= '0;
      o_q        <= '0;
      sfb_q      <= '0;
      j_q        <= '0;
      w_q        <= '0;
      base_q     <= '0;
      wn_q       <= '0;
    end else begin
      f_state_q <= f_state_d;
      if (si_acc) begin
        bm_q[fb_q]    <= '0;
        short_q[fb_q] <= si_short;
        mixed_q[fb_q] <= si_short && mixed_block_flag;
      end
      if (din_acc) begin
        if (in_range) bm_q[fb_q][x_base_in] <= 1'b1;
        if (din_last) begin
          full_q[fb_q] <= 1'b1;
          fb_q         <= fb_q ^ PP;
        end
      end
      // Drain: output register doubles as the synchronous RAM read stage.
      if (adv) begin
        if (iss_done_q) begin
          vld_q        <= 1'b0;
          iss_done_q   <= 1'b0;
          full_q[db_q] <= 1'b0;
          db_q         <= db_q ^ PP;
          o_q          <= '0;
          sfb_q        <= '0;
          j_q          <= '0;
          w_q          <= '0;
          base_q       <= '0;
          wn_q         <= '0;
        end else begin
          vld_q      <= 1'b1;
          x_out_q    <= bm_q[db_q][rd_addr] ? mem_q[db_q][rd_addr] : '0;
          idx_q      <= o_q;
          iss_done_q <= (o_q == LAST_IDX);
          o_q        <= o_d;
          sfb_q      <= sfb_d;
          j_q        <= j_d;
          w_q        <= w_d;
          base_q     <= base_d;
          wn_q       <= wn_d;
        end
      end
    end
  end

  assign dout_valid = vld_q;
  assign x_out      = x_out_q;
  assign x_idx_out  = idx_q;
  assign busy       = (f_state_q != ST_IDLE) || (|full_q);

endmodule
